// File: rtl/mult4_seq_ctrl.sv
// mult4_seq_ctrl -- sequencing FSM for the 2x2-partial-product multiplier.
//
// Drives the datapath through LOAD and four Horner steps to build an unsigned
// 4x4 -> 8-bit product:
//     acc = ((aH*bH) << 2) + aH*bL, then acc = ((acc + aL*bH) << 2) + aL*bL
// The controller does no arithmetic. It only sequences load, clear, half
// selects, shift select and accumulator enable.
//
// Optional build macro: MULT_CTRL_ABORT_EN
//     When it is defined, an abort input is added. Asserting it in LOAD or in
//     any MUL state returns the FSM to IDLE without flagging done.
//     When it is undefined, every accepted start runs to DONE.
//
// All outputs are registered. They are decoded from the next state, so each
// output is valid for the whole cycle in which its state is current.
module mult4_seq_ctrl #(
    parameter int DONE_PULSE = 0,   // 1: done is a one-cycle pulse; 0: done holds until ack
    parameter int ST_W       = 3    // state register width (encoding fixed, 7 states)
) (
    input  logic       clk,
    input  logic       rst,         // synchronous, active-low
    input  logic       start,
    input  logic       ack,
`ifdef MULT_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic       ld,
    output logic       dp_clr,
    output logic       acc_en,
    output logic       s0,
    output logic       s2,
    output logic       s1,
    output logic       busy,
    output logic       done,
    output logic [1:0] step
);

    // State encoding is fixed so the state register stays readable in debug views.
    typedef enum logic [ST_W-1:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL0 = 3'd2,
        MUL1 = 3'd3,
        MUL2 = 3'd4,
        MUL3 = 3'd5,
        DONE = 3'd6
    } state_t;

    // Control word that is registered alongside the state.
    typedef struct packed {
        logic       ld;
        logic       dp_clr;
        logic       acc_en;
        logic       s0;
        logic       s2;
        logic       s1;
        logic       busy;
        logic       done;
        logic [1:0] step;
    } ctrl_t;

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl_reg;
    logic   abort_req;
    logic   in_operation;

`ifdef MULT_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Abort only matters while an operation is in flight. It is ignored in IDLE and DONE.
    assign in_operation = (state_reg == LOAD) || (state_reg == MUL0) ||
                          (state_reg == MUL1) || (state_reg == MUL2) ||
                          (state_reg == MUL3);

    // Map a state to the control word the datapath needs while in that state.
    // Per step, {s0,s2,s1} walks aH*bH, aH*bL (shifted), aL*bH, aL*bL (shifted).
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            LOAD: begin
                c.ld     = 1'b1;
                c.dp_clr = 1'b1;
                c.busy   = 1'b1;
            end
            MUL0: begin
                c.acc_en = 1'b1;
                c.busy   = 1'b1;
                c.s0     = 1'b1;
                c.s2     = 1'b1;
                c.s1     = 1'b0;
                c.step   = 2'd0;
            end
            MUL1: begin
                c.acc_en = 1'b1;
                c.busy   = 1'b1;
                c.s0     = 1'b1;
                c.s2     = 1'b0;
                c.s1     = 1'b1;
                c.step   = 2'd1;
            end
            MUL2: begin
                c.acc_en = 1'b1;
                c.busy   = 1'b1;
                c.s0     = 1'b0;
                c.s2     = 1'b1;
                c.s1     = 1'b0;
                c.step   = 2'd2;
            end
            MUL3: begin
                c.acc_en = 1'b1;
                c.busy   = 1'b1;
                c.s0     = 1'b0;
                c.s2     = 1'b0;
                c.s1     = 1'b1;
                c.step   = 2'd3;
            end
            DONE: begin
                c.busy   = 1'b1;
                c.done   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection: fixed walk through the steps; DONE exits on pulse mode or ack.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = LOAD;
            LOAD: state_next = MUL0;
            MUL0: state_next = MUL1;
            MUL1: state_next = MUL2;
            MUL2: state_next = MUL3;
            MUL3: state_next = DONE;
            // A start arriving together with ack is not taken here; it must be seen again in IDLE.
            DONE: if ((DONE_PULSE != 0) || ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort_req && in_operation) begin
            state_next = IDLE;
        end
    end

    // State and control-word registers. Reset clears everything, even mid-multiply.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            ctrl_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= decode(state_next);
        end
    end

    assign ld     = ctrl_reg.ld;
    assign dp_clr = ctrl_reg.dp_clr;
    assign acc_en = ctrl_reg.acc_en;
    assign s0     = ctrl_reg.s0;
    assign s2     = ctrl_reg.s2;
    assign s1     = ctrl_reg.s1;
    assign busy   = ctrl_reg.busy;
    assign done   = ctrl_reg.done;
    assign step   = ctrl_reg.step;

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Bench for mult4_seq_ctrl. It has two instances: a hold-until-ack
// controller (DONE_PULSE=0) and a pulse-mode controller (DONE_PULSE=1).
// Each instance drives a small behavioural datapath, so the final accumulator
// can be checked against a*b. The control outputs are checked cycle by cycle
// against the schedule that follows an accepted start.
module tb_mult4_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    // hold-mode instance signals
    logic       start0 = 1'b0, ack0 = 1'b0;
    logic       ld0, clr0, en0, s0_0, s2_0, s1_0, busy0, done0;
    logic [1:0] step0;
    logic [3:0] opa0 = 4'd0, opb0 = 4'd0;

    // pulse-mode instance signals
    logic       start1 = 1'b0, ack1 = 1'b0;
    logic       ld1, clr1, en1, s0_1, s2_1, s1_1, busy1, done1;
    logic [1:0] step1;
    logic [3:0] opa1 = 4'd0, opb1 = 4'd0;

`ifdef MULT_CTRL_ABORT_EN
    logic abort0 = 1'b0, abort1 = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    mult4_seq_ctrl #(.DONE_PULSE(0), .ST_W(3)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .ack(ack0),
`ifdef MULT_CTRL_ABORT_EN
        .abort(abort0),
`endif
        .ld(ld0), .dp_clr(clr0), .acc_en(en0), .s0(s0_0), .s2(s2_0), .s1(s1_0),
        .busy(busy0), .done(done0), .step(step0)
    );

    mult4_seq_ctrl #(.DONE_PULSE(1), .ST_W(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .ack(ack1),
`ifdef MULT_CTRL_ABORT_EN
        .abort(abort1),
`endif
        .ld(ld1), .dp_clr(clr1), .acc_en(en1), .s0(s0_1), .s2(s2_1), .s1(s1_1),
        .busy(busy1), .done(done1), .step(step1)
    );

    // Control word layout: {ld, dp_clr, acc_en, s0, s2, s1, busy, done, step}
    logic [9:0] word0, word1;
    assign word0 = {ld0, clr0, en0, s0_0, s2_0, s1_0, busy0, done0, step0};
    assign word1 = {ld1, clr1, en1, s0_1, s2_1, s1_1, busy1, done1, step1};

    // Behavioural datapath driven by each controller
    logic [3:0] a0, b0, a1, b1;
    logic [7:0] acc0, acc1;
    logic [7:0] pp0, pp1;
    assign pp0 = {6'd0, (s0_0 ? a0[3:2] : a0[1:0])} * {6'd0, (s2_0 ? b0[3:2] : b0[1:0])};
    assign pp1 = {6'd0, (s0_1 ? a1[3:2] : a1[1:0])} * {6'd0, (s2_1 ? b1[3:2] : b1[1:0])};

    always @(posedge clk) begin
        if (ld0) begin a0 <= opa0; b0 <= opb0; end
        if (clr0)     acc0 <= 8'd0;
        else if (en0) acc0 <= (s1_0 ? {acc0[5:0], 2'b00} : acc0) + pp0;
        if (ld1) begin a1 <= opa1; b1 <= opb1; end
        if (clr1)     acc1 <= 8'd0;
        else if (en1) acc1 <= (s1_1 ? {acc1[5:0], 2'b00} : acc1) + pp1;
    end

    // Expected control word for cycle i after start is accepted:
    // 0=LOAD, 1..4=MUL0..MUL3, 5=DONE, anything else=idle.
    function automatic logic [9:0] exp_word(input int i);
        logic [2:0] sel;
        case (i)
            0: return {1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0};
            1, 2, 3, 4: begin
                case (i)
                    1: sel = 3'b110;
                    2: sel = 3'b101;
                    3: sel = 3'b010;
                    default: sel = 3'b001;
                endcase
                return {2'b00, 1'b1, sel, 1'b1, 1'b0, 2'(i - 1)};
            end
            5: return {6'b000000, 1'b1, 1'b1, 2'd0};
            default: return 10'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (word0 !== 10'd0 || word1 !== 10'd0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got0=%b got1=%b want=0", i, word0, word1);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (word0 !== 10'd0 || word1 !== 10'd0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got0=%b got1=%b want=0", i, word0, word1);
            end
        end
        $display("test_reset complete");
    endtask

    // One product on the hold-mode instance. When noise is set, start and ack
    // are toggled randomly where they must be ignored.
    task automatic run_mult0(input logic [3:0] a, input logic [3:0] b, input int hold, input bit noise);
        logic [7:0] prod;
        prod = 8'(int'(a) * int'(b));
        opa0 = a; opb0 = b; start0 = 1'b1; ack0 = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            tick();
            total++;
            if (word0 !== exp_word(i)) begin
                bad++;
                $display("FAIL mult0_ctrl a=%0d b=%0d cyc=%0d got=%b want=%b", a, b, i, word0, exp_word(i));
            end
            if (i == 5) begin
                total++;
                if (acc0 !== prod) begin
                    bad++;
                    $display("FAIL mult0_acc a=%0d b=%0d got=%0d want=%0d", a, b, acc0, prod);
                end
            end
            if (i >= 1) begin opa0 = 4'($urandom); opb0 = 4'($urandom); end
            start0 = noise ? 1'($urandom) : 1'b0;
            ack0   = (noise && i < 5) ? 1'($urandom) : 1'b0;
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            total++;
            if (word0 !== exp_word(5) || acc0 !== prod) begin
                bad++;
                $display("FAIL mult0_hold a=%0d b=%0d h=%0d got=%b acc=%0d want=%b acc=%0d",
                         a, b, h, word0, acc0, exp_word(5), prod);
            end
            start0 = noise ? 1'($urandom) : 1'b0;
        end
        ack0 = 1'b1;
        start0 = noise;
        tick();
        ack0 = 1'b0; start0 = 1'b0;
        total++;
        if (word0 !== 10'd0) begin
            bad++;
            $display("FAIL mult0_exit a=%0d b=%0d got=%b want=0", a, b, word0);
        end
        tick();
        total++;
        if (word0 !== 10'd0) begin
            bad++;
            $display("FAIL mult0_idle a=%0d b=%0d got=%b want=0", a, b, word0);
        end
        $display("mult0 a=%0d b=%0d acc=%0d expected=%0d hold=%0d", a, b, acc0, prod, hold);
    endtask

    // One product on the pulse-mode instance. done lasts one cycle, then busy drops.
    task automatic run_mult1(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] prod;
        prod = 8'(int'(a) * int'(b));
        opa1 = a; opb1 = b; start1 = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            tick();
            total++;
            if (word1 !== exp_word(i)) begin
                bad++;
                $display("FAIL mult1_ctrl a=%0d b=%0d cyc=%0d got=%b want=%b", a, b, i, word1, exp_word(i));
            end
            if (i >= 5) begin
                total++;
                if (acc1 !== prod) begin
                    bad++;
                    $display("FAIL mult1_acc a=%0d b=%0d cyc=%0d got=%0d want=%0d", a, b, i, acc1, prod);
                end
            end
            if (i >= 1) begin opa1 = 4'($urandom); opb1 = 4'($urandom); end
            start1 = (i >= 1 && i <= 4) ? 1'($urandom) : 1'b0;
            ack1   = 1'($urandom);
        end
        ack1 = 1'b0;
        $display("mult1 a=%0d b=%0d acc=%0d expected=%0d", a, b, acc1, prod);
    endtask

    task automatic test_product();
        run_mult0(4'hF, 4'hD, 3, 1'b0);
        run_mult0(4'h0, 4'h7, 0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            run_mult0(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end
    endtask

    task automatic test_pulse();
        run_mult1(4'd3, 4'd2);
        run_mult1(4'hF, 4'hF);
        for (int k = 0; k < 6; k++) begin
            run_mult1(4'($urandom), 4'($urandom));
        end
    endtask

    // start is held high the whole time and ack is given in the first DONE
    // cycle, so LOAD should repeat every 7 cycles.
    task automatic test_back_to_back();
        logic [7:0] prod;
        opa0 = 4'($urandom); opb0 = 4'($urandom);
        prod = 8'(int'(opa0) * int'(opb0));
        start0 = 1'b1; ack0 = 1'b0;
        for (int c = 0; c < 21; c++) begin
            tick();
            total++;
            if (word0 !== exp_word(c % 7)) begin
                bad++;
                $display("FAIL b2b_ctrl cyc=%0d got=%b want=%b", c, word0, exp_word(c % 7));
            end
            if (c % 7 == 5) begin
                total++;
                if (acc0 !== prod) begin
                    bad++;
                    $display("FAIL b2b_acc cyc=%0d got=%0d want=%0d", c, acc0, prod);
                end
            end
            ack0 = (c % 7 == 5);
            if (c == 20) start0 = 1'b0;
        end
        ack0 = 1'b0;
        tick();
        total++;
        if (word0 !== 10'd0) begin
            bad++;
            $display("FAIL b2b_idle got=%b want=0", word0);
        end
        $display("back_to_back a=%0d b=%0d acc=%0d expected=%0d", opa0, opb0, acc0, prod);
    endtask

    task automatic test_reset_mid();
        opa0 = 4'd5; opb0 = 4'd6; start0 = 1'b1;
        for (int i = 0; i <= 3; i++) begin
            tick();
            start0 = 1'b0;
        end
        total++;
        if (word0 !== exp_word(3)) begin
            bad++;
            $display("FAIL rstmid_pre got=%b want=%b", word0, exp_word(3));
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++;
        if (word0 !== 10'd0) begin
            bad++;
            $display("FAIL rstmid_cut got=%b want=0", word0);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (word0 !== 10'd0) begin
                bad++;
                $display("FAIL rstmid_nodone cyc=%0d got=%b want=0", i, word0);
            end
        end
        $display("reset_mid operation dropped");
        run_mult0(4'd9, 4'd9, 1, 1'b0);
    endtask

`ifdef MULT_CTRL_ABORT_EN
    task automatic test_abort();
        opa0 = 4'd7; opb0 = 4'd3; start0 = 1'b1;
        for (int i = 0; i <= 2; i++) begin
            tick();
            start0 = 1'b0;
        end
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        total++;
        if (word0 !== 10'd0) begin
            bad++;
            $display("FAIL abort_cut got=%b want=0", word0);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (word0 !== 10'd0) begin
                bad++;
                $display("FAIL abort_nodone cyc=%0d got=%b want=0", i, word0);
            end
        end
        // abort in DONE is ignored
        opa0 = 4'd2; opb0 = 4'd4; start0 = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            tick();
            start0 = 1'b0;
        end
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        total++;
        if (word0 !== exp_word(5) || acc0 !== 8'd8) begin
            bad++;
            $display("FAIL abort_done got=%b acc=%0d want=%b acc=8", word0, acc0, exp_word(5));
        end
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        $display("abort sequence complete");
        run_mult0(4'd15, 4'd15, 1, 1'b0);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_product();
        test_pulse();
        test_back_to_back();
        test_reset_mid();
`ifdef MULT_CTRL_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult4_seq_ctrl.md
Name: mult4_seq_ctrl

Overview:
Control FSM that sequences the 2x2-partial-product datapath to compute an unsigned 4x4 -> 8-bit product.
- Accepts a start/ack handshake from the host.
- Drives operand load, operand-half selects, accumulator clear, accumulator enable and shift select.
- Generates the four Horner steps and flags completion.
- Sits between the host and the datapath; it performs no arithmetic itself.

Parameters:
DONE_PULSE, 0, 1: done is a one-cycle pulse and the FSM returns to IDLE by itself; 0: done holds until ack.
ST_W, 3, state register width (fixed encoding, 7 states used).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
start  input  1  request a multiply; sampled only in IDLE
ack  input  1  host consumed result; used only when DONE_PULSE=0
ld  output  1  load operand registers a/b from the input buses
dp_clr  output  1  clear the 8-bit accumulator (active-high, one cycle)
acc_en  output  1  accumulator captures adder output this edge
s0  output  1  a-half select: 1 = a[3:2], 0 = a[1:0]
s2  output  1  b-half select: 1 = b[3:2], 0 = b[1:0]
s1  output  1  accumulator path select: 1 = (acc<<2), 0 = acc
busy  output  1  high from start acceptance until DONE is left
done  output  1  accumulator holds a valid product
step  output  2  current multiply step index (debug/visibility)

Behaviour:
- Reset, sampled on a clk edge with rst=0:
  - state=IDLE.
  - All outputs 0; step=0.
  - Reset wins over every other input in the same cycle, including mid-multiply; no partial result is flagged.
- States: IDLE, LOAD, MUL0, MUL1, MUL2, MUL3, DONE.
- IDLE:
  - Outputs 0.
  - start=1 -> LOAD next edge.
  - start=0 -> stay.
- LOAD (1 cycle):
  - ld=1, dp_clr=1, busy=1, acc_en=0.
  - -> MUL0.
- MULk (1 cycle each): acc_en=1, busy=1, step=k. Selects per step:
  - MUL0: s0=1, s2=1, s1=0 (acc = aH*bH; acc already 0).
  - MUL1: s0=1, s2=0, s1=1 (acc = (acc<<2) + aH*bL).
  - MUL2: s0=0, s2=1, s1=0 (acc = acc + aL*bH).
  - MUL3: s0=0, s2=0, s1=1 (acc = (acc<<2) + aL*bL).
  - Then -> DONE.
- Arithmetic: the accumulator is 8 bits and the shift is a left shift by 2, zero-fill. The max product 225 fits, so no overflow.
- DONE:
  - done=1, busy=1, acc_en=0, so the accumulator is frozen.
  - DONE_PULSE=1: -> IDLE next edge; done lasts exactly one cycle.
  - DONE_PULSE=0: stay until ack=1, then -> IDLE.
  - ack and start both high in DONE: go to IDLE only; start must be re-sampled in IDLE.
- Latency: start sampled high at edge N -> done high during cycle N+5 (LOAD, MUL0-3, then DONE).
- start while busy is ignored, not queued. ack outside DONE is ignored.
- Selects in non-MUL states are 0. dp_clr and ld are never high outside LOAD.
- Operand buses need only be stable at the LOAD edge.

Optional Feature:
MULT_CTRL_ABORT_EN
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in LOAD or any MULk -> IDLE next edge; busy=0 and done never asserts for that operation.
  - Accumulator contents are left as-is; the next LOAD clears them.
  - abort in IDLE or DONE is ignored.
  - rst=0 has priority over abort.
- Undefined: no abort port; the sequence always runs to DONE.

Test Plan:
1. Reset then idle: rst=0 for 2 cycles, then rst=1, start=0 for 5 cycles -> all outputs 0, state IDLE throughout.
2. Product sequence: a=4'hF, b=4'hD, start pulse, DONE_PULSE=0.
   - LOAD: ld=1, dp_clr=1.
   - MUL0-MUL3 (s0,s2,s1) sequence: 110, 101, 010, 001.
   - Datapath accumulator reads 8'd195 when done rises 5 cycles after start; stays 195 until ack.
3. Latency and pulse mode: DONE_PULSE=1, a=3, b=2 -> done high exactly one cycle at N+5 with acc=6; busy falls the cycle after.
4. Busy collision: start held high continuously -> a second LOAD occurs only after returning to IDLE. No ld pulse during MUL0-3 or DONE; with ack at the first DONE cycle, LOAD pulses are 7 cycles apart.
5. Reset mid-operation: rst=0 during MUL2 -> next edge IDLE, busy=0, done never asserts; a fresh start with a=9, b=9 yields 81.
6. Abort (macro defined): abort=1 in MUL1 -> IDLE next edge, no done. A following start with a=15, b=15 yields 225.
